// File: rtl/arith_unit_seq.sv
// rtl/arith_unit_seq.sv - sequential add/sub/mul/div unit with start/done handshake
// Mul is shift-add and div is restoring division, one bit per cycle.
module arith_unit_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               carry,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH:0]     acc_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     quo_q;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH:0]       addsub_res;
  logic [WIDTH:0]       mul_upper;
  logic [2*WIDTH:0]     mul_nxt;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH:0]       div_rem_nxt;
  logic [WIDTH-1:0]     div_quo_nxt;

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign accept    = start && !busy;
  assign last_iter = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (!op[1])               state_d = S_ADDSUB;
          else if (!op[0])          state_d = S_MUL;
          else if (b == '0)         state_d = S_ADDSUB;
          else                      state_d = S_DIV;
        end
      end
      S_ADDSUB:     state_d = S_DONE;
      S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath next values; bit WIDTH of the sub result is the borrow.
  always_comb begin
    addsub_res  = op_q[0] ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    mul_upper   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt     = {mul_upper, acc_q[WIDTH-1:0]} >> 1;
    div_shift   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, b_q});
    div_rem_nxt = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
    div_quo_nxt = {quo_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      sum         <= '0;
      carry       <= 1'b0;
      product     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_ADDSUB: begin
          // Divide-by-zero shares the single-cycle path with add/sub.
          if (op_q == 2'b11) begin
            quotient    <= '1;
            remainder   <= a_q;
            div_by_zero <= 1'b1;
          end else begin
            sum   <= addsub_res[WIDTH-1:0];
            carry <= addsub_res[WIDTH];
          end
        end
        S_MUL: begin
          acc_q <= mul_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (last_iter) product <= mul_nxt[2*WIDTH-1:0];
        end
        S_DIV: begin
          rem_q <= div_rem_nxt;
          quo_q <= div_quo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (last_iter) begin
            quotient    <= div_quo_nxt;
            remainder   <= div_rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        cnt_q <= CW'(WIDTH);
        acc_q <= {{(WIDTH+1){1'b0}}, b};
        rem_q <= '0;
        quo_q <= a;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// tb/tb_arith_unit_seq.sv - directed self-checking bench for arith_unit_seq
// Expected values are hand-computed for WIDTH=4.
module tb_arith_unit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [3:0] a, b;
  logic       busy, done, carry, div_by_zero;
  logic [3:0] sum, quotient, remainder;
  logic [7:0] product;

  int tests_run;
  int tests_failed;
  int done_cnt;

  arith_unit_seq #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .carry       (carry),
    .product     (product),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_carry"}, carry, 0);
    chk({tag, "_product"}, product, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask

  // Called just after a negedge; returns at the negedge where done is high.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] x,
                        input logic [3:0] y, input int lat);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    int n;
    tests_run = 0; tests_failed = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add", 2'b00, 4'd9, 4'd8, 1);
    chk("add_sum", sum, 4'h1);
    chk("add_carry", carry, 1);
    chk("add_product", product, 0);
    chk("add_quotient", quotient, 0);
    chk("add_remainder", remainder, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    run_op("sub1", 2'b01, 4'd3, 4'd5, 1);
    chk("sub1_sum", sum, 4'hE);
    chk("sub1_borrow", carry, 1);
    run_op("sub2", 2'b01, 4'd5, 4'd3, 1);
    chk("sub2_sum", sum, 4'h2);
    chk("sub2_borrow", carry, 0);

    run_op("mul", 2'b10, 4'd15, 4'd15, 4);
    chk("mul_product", product, 8'hE1);
    chk("mul_sum_held", sum, 4'h2);

    run_op("div", 2'b11, 4'd13, 4'd4, 4);
    chk("div_quotient", quotient, 4'h3);
    chk("div_remainder", remainder, 4'h1);
    chk("div_dbz", div_by_zero, 0);
    run_op("div0", 2'b11, 4'd7, 4'd0, 1);
    chk("div0_quotient", quotient, 4'hF);
    chk("div0_remainder", remainder, 4'h7);
    chk("div0_dbz", div_by_zero, 1);
    chk("div0_product_held", product, 8'hE1);
    @(negedge clk);

    // Start pulse during a mul must be ignored.
    done_cnt = 0;
    op = 2'b10; a = 4'd6; b = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 2'b00; a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    while (!done && n < 20) begin
      @(negedge clk);
      if (!done) n++;
    end
    chk("ign_latency", n, 4);
    chk("ign_product", product, 8'd42);
    chk("ign_sum_held", sum, 4'h2);
    repeat (4) @(negedge clk);
    chk("ign_done_count", done_cnt, 1);

    // Back-to-back: second start issued in the DONE cycle.
    run_op("b2b_add", 2'b00, 4'd1, 4'd2, 1);
    chk("b2b_add_sum", sum, 4'h3);
    run_op("b2b_mul", 2'b10, 4'd3, 4'd5, 4);
    chk("b2b_mul_product", product, 8'd15);
    @(negedge clk);

    // Reset during cycle 2 of a division.
    done_cnt = 0;
    op = 2'b11; a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_div", 2'b11, 4'd9, 4'd2, 4);
    chk("post_rst_quotient", quotient, 4'd4);
    chk("post_rst_remainder", remainder, 4'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
